// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: consumes the main-store stream LSB first on the DPG beat
// clock, performs LDN/SUB/ZERO serially and commits the result at the first flyback beat.
module serial_accumulator #(
    parameter int WORD_BITS    = 32,
    parameter int FLYBACK_TIME = 4
) (
    input  logic                                      w_DPG,
    input  logic                                      w_RST_N,
    input  logic                                      w_MS_DATA_IN,
    input  logic [1:0]                                b_A_OP,
    input  logic                                      w_A_OP_VALID,
    output logic                                      w_A_DATA_OUT,
    output logic [WORD_BITS-1:0]                      b_A_VALUE,
    output logic                                      w_A_NEG,
    output logic                                      w_A_OVF,
    output logic                                      w_A_BUSY,
    output logic [$clog2(WORD_BITS+FLYBACK_TIME):0]   b_A_BEAT,
    output logic                                      w_A_BEAT0
);

    localparam int PERIOD = WORD_BITS + FLYBACK_TIME;
    localparam int BW     = $clog2(PERIOD) + 1;
    localparam int IW     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(PERIOD - 1);
    localparam logic [BW-1:0] COMMIT_BEAT = BW'(WORD_BITS);
    localparam logic [BW-1:0] MSB_BEAT = BW'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LDN  = 2'b01,
        OP_SUB  = 2'b10,
        OP_ZERO = 2'b11
    } op_t;

    logic [BW-1:0]        r_beat;
    logic [WORD_BITS-1:0] r_acc;
    logic [WORD_BITS-1:0] r_shadow;
    logic                 r_borrow;
    op_t                  r_op;
    logic                 r_busy;
    logic                 r_ovf;
    logic                 r_ovfPend;
    logic                 r_dout;

    logic          w_beatZero;
    logic          w_dataBeat;
    logic          w_lastBeat;
    logic          w_start;
    logic          w_step;
    op_t           w_activeOp;
    logic [IW-1:0] w_idx;
    logic          w_a;
    logic          w_bin;
    logic          w_r;
    logic          w_bout;
    logic          w_ovfBit;

    // At beat 0 the op has not been latched yet, so bit 0 works from the request itself.
    always_comb begin
        w_beatZero = (r_beat == '0);
        w_dataBeat = (r_beat < COMMIT_BEAT);
        w_lastBeat = (r_beat == MSB_BEAT);
        w_idx      = r_beat[IW-1:0];
        w_start    = w_beatZero && w_A_OP_VALID && (b_A_OP != OP_HOLD);
        w_step     = w_start || (r_busy && w_dataBeat);
        w_activeOp = w_beatZero ? op_t'(b_A_OP) : r_op;
        w_bin      = w_beatZero ? 1'b0 : r_borrow;
        w_a        = 1'b0;
        w_r        = 1'b0;
        w_bout     = 1'b0;
        w_ovfBit   = 1'b0;
        if (w_dataBeat && (w_activeOp == OP_SUB)) begin
            w_a = r_acc[w_idx];
        end
        case (w_activeOp)
            OP_LDN, OP_SUB: begin
                w_r    = w_a ^ w_MS_DATA_IN ^ w_bin;
                w_bout = (~w_a & (w_MS_DATA_IN | w_bin)) | (w_MS_DATA_IN & w_bin);
                // LDN is SUB from zero, so one sign rule covers both.
                w_ovfBit = (w_a != w_MS_DATA_IN) && (w_r != w_a);
            end
            default: begin
                w_r    = 1'b0;
                w_bout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_DPG or negedge w_RST_N) begin
        if (!w_RST_N) begin
            r_beat    <= '0;
            r_acc     <= '0;
            r_shadow  <= '0;
            r_borrow  <= 1'b0;
            r_op      <= OP_HOLD;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_ovfPend <= 1'b0;
            r_dout    <= 1'b0;
        end else begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
            r_dout <= w_dataBeat ? r_acc[w_idx] : 1'b0;
            if (w_start) begin
                r_busy <= 1'b1;
                r_op   <= op_t'(b_A_OP);
            end
            if (w_step) begin
                r_shadow[w_idx] <= w_r;
                r_borrow        <= w_bout;
                if (w_lastBeat) begin
                    r_ovfPend <= w_ovfBit;
                end
            end
            // Final borrow is dropped: the result is taken modulo 2^WORD_BITS.
            if (r_busy && (r_beat == COMMIT_BEAT)) begin
                r_acc  <= r_shadow;
                r_ovf  <= r_ovfPend;
                r_busy <= 1'b0;
            end
        end
    end

    assign w_A_DATA_OUT = r_dout;
    assign b_A_VALUE    = r_acc;
    assign w_A_NEG      = r_acc[WORD_BITS-1];
    assign w_A_OVF      = r_ovf;
    assign w_A_BUSY     = r_busy;
    assign b_A_BEAT     = r_beat;
    assign w_A_BEAT0    = (r_beat == '0);

endmodule

// File: doc/serial_accumulator.md
Name: serial_accumulator

Overview:
- Parametrised bit-serial accumulator for the reduced machine. It is the successor to the separate accumulator write unit, read unit and store.
- Consumes the main-store serial stream (LSB first) on the DPG beat clock and performs the machine's accumulator arithmetic serially: load-negative, subtract and clear.
- Regenerates the committed value serially for downstream units and exposes a parallel copy, sign, overflow and beat timing.
- Sits between the main store serial output and the control unit's test/branch logic.

Parameters:
- WORD_BITS, 32, accumulator/store word width; data beats per period.
- FLYBACK_TIME, 4, idle beats after the data beats; period = WORD_BITS+FLYBACK_TIME.

Ports:
- w_DPG  input  1  beat clock; all state on rising edge.
- w_RST_N  input  1  asynchronous active-low reset.
- w_MS_DATA_IN  input  1  serial operand from main store; bit k valid during beat k, k < WORD_BITS.
- b_A_OP  input  2  operation: 00 HOLD, 01 LDN, 10 SUB, 11 ZERO.
- w_A_OP_VALID  input  1  op request; sampled only at beat 0.
- w_A_DATA_OUT  output  1  serial committed accumulator, LSB first; 0 in flyback.
- b_A_VALUE  output  WORD_BITS  parallel committed accumulator.
- w_A_NEG  output  1  sign bit of committed accumulator (b_A_VALUE[WORD_BITS-1]).
- w_A_OVF  output  1  signed overflow of the last committed LDN/SUB.
- w_A_BUSY  output  1  op in progress (beats 0..WORD_BITS-1 of an active period).
- b_A_BEAT  output  $clog2(WORD_BITS+FLYBACK_TIME)+1  current beat counter.
- w_A_BEAT0  output  1  high while b_A_BEAT == 0.

Behaviour:
- Reset (async, w_RST_N low):
  - Beat counter, accumulator, shadow, borrow, latched op, w_A_DATA_OUT, w_A_OVF and w_A_BUSY are all 0.
  - An in-flight op is discarded; acc keeps 0.
- Beat counter:
  - "Edge at beat k" means the rising edge while the counter equals k.
  - Counter increments each edge and wraps from WORD_BITS+FLYBACK_TIME-1 to 0.
- Op acceptance:
  - At the beat-0 edge with w_A_OP_VALID=1 and b_A_OP≠HOLD, the op latches and w_A_BUSY is set.
  - Bit 0 is computed on that same edge using b_A_OP directly.
  - w_A_OP_VALID is ignored at every other beat. HOLD or valid=0 at beat 0 leaves the period idle.
- Serial arithmetic, at the edge at beat k < WORD_BITS while busy. Let a = acc[k], d = w_MS_DATA_IN, bin = borrow (forced 0 at k=0).
  - LDN: r = 0 − d − bin.
  - SUB: r = a − d − bin.
  - ZERO: r = 0, borrow stays 0.
  - shadow[k] <= r. Borrow <= borrow-out of r.
- Commit at the edge at beat WORD_BITS (first flyback beat), if busy:
  - acc <= shadow; w_A_BUSY <= 0.
  - The final borrow is discarded (modulo 2^WORD_BITS).
  - w_A_OVF <= 1 for LDN when d == 100…0; for SUB when sign(a)≠sign(d) and sign(result)≠sign(a). Otherwise 0.
  - ZERO clears w_A_OVF. An idle period leaves acc and w_A_OVF unchanged.
- Serial output:
  - At the edge at beat k < WORD_BITS, w_A_DATA_OUT <= acc[k], so bit k appears one cycle after beat k. Otherwise it is driven to 0.
  - During an op it streams the pre-op value. The new value streams from the next period.
- Flags: b_A_VALUE and w_A_NEG change only at commit or reset.
- Mid-period reset: the op aborts and the counter restarts at 0 on release; the next op is accepted at the first beat-0 edge after release.

Test Plan (WORD_BITS=8, FLYBACK_TIME=4):
1. Assert w_RST_N=0, then release → all outputs 0, b_A_BEAT counts 0..11 and wraps to 0, w_A_BEAT0 high 1 beat in 12.
2. LDN with data 0x05 → busy beats 0–7; at beat 8 acc=0xFB, NEG=1, OVF=0; next period w_A_DATA_OUT streams 1,1,0,1,1,1,1,1 then 0,0,0,0.
3. SUB with acc=0xFB, data 0x03 → acc=0xF8, OVF=0; during the SUB period the serial out still streams 0xFB.
4. LDN 0x80 → acc=0x80, OVF=1. Then SUB data 0x01 → acc=0x7F, NEG=0, OVF=1. Then SUB data 0x01 → acc=0x7E, OVF=0.
5. ZERO → acc=0x00, OVF=0. Op valid with SUB asserted at beat 3 only → ignored, acc stays 0, busy never set.
6. With acc=0x10, start SUB 0x01 and assert reset at beat 5 → acc=0, busy=0, counter=0. After release, LDN 0x02 → acc=0xFE.
